// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state encoding and iterative-unit mode for seq_alu.
// Imported by the interface consumers, the top and the iterative datapath.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_ROL  = 4'b0110;
    localparam logic [3:0] OP_ROR  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_NAND = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b1110;
    localparam logic [3:0] OP_SRA  = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    typedef enum logic {
        MODE_DIV = 1'b0,
        MODE_MUL = 1'b1
    } iter_mode_e;

endpackage

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: master drives operands and
// out_ready, slave (the ALU) drives in_ready, result and flags.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             carry_out;
    logic             zero;
    logic             div_by_zero;

    modport master (
        output in_valid, a, b, alu_sel, out_ready,
        input  in_ready, out_valid, alu_out, carry_out, zero, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, alu_sel, out_ready,
        output in_ready, out_valid, alu_out, carry_out, zero, div_by_zero
    );
endinterface

// File: rtl/seq_alu_iter.sv
// Iterative datapath: restoring divider, and a shift-add multiplier unless
// SEQ_ALU_MUL_HW_EN is defined. One result bit/partial product per cycle.
module seq_alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  iter_mode_e       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int SHW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;   // partial remainder or running product
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend/quotient or shifting multiplier
    logic [WIDTH-1:0] opb_q, opb_d;   // divisor or shifting multiplicand
    iter_mode_e       mode_q, mode_d;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    always_comb begin
        busy_d    = busy_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        opb_d     = opb_q;
        mode_d    = mode_q;
        rem_shift = {acc_q, quo_q[WIDTH-1]};
        trial     = rem_shift - {1'b0, opb_q};
        if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            acc_d  = '0;
            quo_d  = a;
            opb_d  = b;
            mode_d = mode;
        end else if (busy_q) begin
`ifndef SEQ_ALU_MUL_HW_EN
            if (mode_q == MODE_MUL) begin
                acc_d = acc_q + (quo_q[0] ? opb_q : '0);
                quo_d = quo_q >> 1;
                opb_d = opb_q << 1;
            end else
`endif
            begin
                // trial[WIDTH] set means the shifted remainder is below the divisor
                if (!trial[WIDTH]) begin
                    acc_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == SHW'(WIDTH - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            acc_q  <= '0;
            quo_q  <= '0;
            opb_q  <= '0;
            mode_q <= MODE_DIV;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            quo_q  <= quo_d;
            opb_q  <= opb_d;
            mode_q <= mode_d;
        end
    end

    // Results are the values being written on the final step, so the caller
    // registers them on the same edge the iteration completes.
    assign done      = busy_q && (cnt_q == SHW'(WIDTH - 1));
    assign quotient  = (mode_q == MODE_MUL) ? acc_d : quo_d;
    assign remainder = acc_d;

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU with valid/ready on input and output. Define
// SEQ_ALU_MUL_HW_EN for a single-cycle multiplier instead of the iterative one.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    seq_alu_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;

    logic             in_ready, out_valid, accept;
    logic             is_iter, is_div0;
    logic [SHW-1:0]   sh;
    logic [WIDTH:0]   add_sum;
    logic [2*WIDTH-1:0] rol_ext, ror_ext;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;

    logic             iter_done;
    logic [WIDTH-1:0] iter_res, iter_rem;
    logic             unused_rem;
    iter_mode_e       iter_mode;

    assign sh       = bus.b[SHW-1:0];
    assign accept   = in_ready && bus.in_valid;
    assign is_div0  = (bus.alu_sel == OP_DIV) && (bus.b == '0);
    assign iter_mode = (bus.alu_sel == OP_MUL) ? MODE_MUL : MODE_DIV;
    assign unused_rem = ^iter_rem;

    always_comb begin
        is_iter = (bus.alu_sel == OP_DIV) && (bus.b != '0);
`ifndef SEQ_ALU_MUL_HW_EN
        if (bus.alu_sel == OP_MUL) begin
            is_iter = 1'b1;
        end
`endif
    end

    // Single-cycle results, evaluated on the operands presented at acceptance
    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        add_sum  = {1'b0, bus.a} + {1'b0, bus.b};
        rol_ext  = {bus.a, bus.a} << sh;
        ror_ext  = {bus.a, bus.a} >> sh;
        case (bus.alu_sel)
            OP_ADD:  begin sc_res = add_sum[WIDTH-1:0]; sc_carry = add_sum[WIDTH]; end
            OP_SUB:  begin sc_res = bus.a - bus.b; sc_carry = (bus.a >= bus.b); end
`ifdef SEQ_ALU_MUL_HW_EN
            OP_MUL:  sc_res = bus.a * bus.b;
`else
            OP_MUL:  sc_res = '0;
`endif
            OP_DIV:  sc_res = '1;
            OP_SLL:  sc_res = bus.a << sh;
            OP_SRL:  sc_res = bus.a >> sh;
            OP_ROL:  sc_res = rol_ext[2*WIDTH-1:WIDTH];
            OP_ROR:  sc_res = ror_ext[WIDTH-1:0];
            OP_AND:  sc_res = bus.a & bus.b;
            OP_OR:   sc_res = bus.a | bus.b;
            OP_XOR:  sc_res = bus.a ^ bus.b;
            OP_NOR:  sc_res = ~(bus.a | bus.b);
            OP_NAND: sc_res = ~(bus.a & bus.b);
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SRA:  sc_res = $signed(bus.a) >>> sh;
            default: sc_res = '0;
        endcase
    end

    seq_alu_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (accept && is_iter),
        .mode     (iter_mode),
        .a        (bus.a),
        .b        (bus.b),
        .done     (iter_done),
        .quotient (iter_res),
        .remainder(iter_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = is_iter ? ST_BUSY : ST_DONE;
            ST_BUSY: if (iter_done)    state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready is held low while reset is asserted
    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
    end

    always_comb begin
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        if (accept) begin
            carry_d = 1'b0;
            zero_d  = 1'b0;
            dbz_d   = 1'b0;
            if (!is_iter) begin
                result_d = sc_res;
                carry_d  = sc_carry;
                zero_d   = (sc_res == '0);
                dbz_d    = is_div0;
            end
        end else if ((state_q == ST_BUSY) && iter_done) begin
            result_d = iter_res;
            zero_d   = (iter_res == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.alu_out     = result_q;
    assign bus.carry_out   = carry_q;
    assign bus.zero        = zero_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu (WIDTH = 32); honours SEQ_ALU_MUL_HW_EN
// when choosing the expected MUL latency.
module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef SEQ_ALU_MUL_HW_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    int   lat;
    int   rdy_seen;

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
        $display("check %-14s observed %h expected %h", tag, got, exp);
    endtask

    // Present one op for a single accepting edge, then count edges (acceptance
    // edge included) until out_valid; rdy counts cycles in_ready was seen high.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] ai, input logic [W-1:0] bi,
                         output int latency, output int rdy);
        @(negedge clk);
        bus.alu_sel  = op;
        bus.a        = ai;
        bus.b        = bi;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        latency = 1;
        rdy     = 0;
        while (!bus.out_valid && latency < 100) begin
            if (bus.in_ready) rdy++;
            @(posedge clk);
            #1;
            latency++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.alu_sel   = OP_ADD;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {bus.out_valid, bus.carry_out, bus.zero, bus.div_by_zero, bus.alu_out},
              {1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {63'b0, bus.in_ready}, 64'd1);

        // ADD overflow to zero
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1, lat, rdy_seen);
        check("add_lat", 64'(lat), 64'd1);
        check("add_res", {bus.carry_out, bus.zero, bus.alu_out}, {1'b1, 1'b1, 32'h0});
        consume();
        check("add_idle", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});

        // Iterative DIV
        issue(OP_DIV, 32'd100, 32'd7, lat, rdy_seen);
        check("div_lat", 64'(lat), 64'd33);
        check("div_busy_rdy", 64'(rdy_seen), 64'd0);
        check("div_res", {bus.in_ready, bus.zero, bus.div_by_zero, bus.carry_out, bus.alu_out},
              {1'b0, 1'b0, 1'b0, 1'b0, 32'd14});
        consume();
        issue(OP_DIV, 32'hFFFF_FFFF, 32'd1, lat, rdy_seen);
        check("div_big", {bus.zero, bus.alu_out}, {1'b0, 32'hFFFF_FFFF});
        consume();
        issue(OP_DIV, 32'd7, 32'd100, lat, rdy_seen);
        check("div_small", {bus.zero, bus.alu_out}, {1'b1, 32'h0});
        consume();

        // Division by zero
        issue(OP_DIV, 32'd100, 32'd0, lat, rdy_seen);
        check("dbz_lat", 64'(lat), 64'd1);
        check("dbz_res", {bus.div_by_zero, bus.carry_out, bus.alu_out}, {1'b1, 1'b0, 32'hFFFF_FFFF});
        consume();

        // SUB both directions; div_by_zero clears on next op
        issue(OP_SUB, 32'd5, 32'd3, lat, rdy_seen);
        check("sub_ge", {bus.div_by_zero, bus.carry_out, bus.alu_out}, {1'b0, 1'b1, 32'd2});
        consume();
        issue(OP_SUB, 32'd3, 32'd5, lat, rdy_seen);
        check("sub_lt", {bus.carry_out, bus.alu_out}, {1'b0, 32'hFFFF_FFFE});
        consume();

        // Shifts and rotates
        issue(OP_SRA, 32'h8000_0000, 32'd4, lat, rdy_seen);
        check("sra", {bus.carry_out, bus.alu_out}, {1'b0, 32'hF800_0000});
        consume();
        issue(OP_ROL, 32'h8000_0001, 32'd1, lat, rdy_seen);
        check("rol", 64'(bus.alu_out), 64'h0000_0003);
        consume();
        issue(OP_ROR, 32'h0000_0001, 32'd1, lat, rdy_seen);
        check("ror", 64'(bus.alu_out), 64'h8000_0000);
        consume();
        issue(OP_SLL, 32'h1234_5678, 32'd32, lat, rdy_seen);
        check("sll_mask0", 64'(bus.alu_out), 64'h1234_5678);
        consume();
        issue(OP_ROL, 32'h1234_5678, 32'd0, lat, rdy_seen);
        check("rol_0", 64'(bus.alu_out), 64'h1234_5678);
        consume();
        issue(OP_SRL, 32'h8000_0000, 32'd31, lat, rdy_seen);
        check("srl", 64'(bus.alu_out), 64'h0000_0001);
        consume();

        // Compares
        issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, lat, rdy_seen);
        check("slt", 64'(bus.alu_out), 64'd1);
        consume();
        issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, lat, rdy_seen);
        check("sltu", {bus.zero, bus.alu_out}, {1'b1, 32'd0});
        consume();

        // Bitwise logic
        issue(OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, rdy_seen);
        check("and", 64'(bus.alu_out), 64'h00F0_000F);
        consume();
        issue(OP_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, rdy_seen);
        check("or", 64'(bus.alu_out), 64'hFFF0_0FFF);
        consume();
        issue(OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, rdy_seen);
        check("xor", 64'(bus.alu_out), 64'hFF00_0FF0);
        consume();
        issue(OP_NOR, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, rdy_seen);
        check("nor", 64'(bus.alu_out), 64'h000F_F000);
        consume();
        issue(OP_NAND, 32'hF0F0_00FF, 32'h0FF0_0F0F, lat, rdy_seen);
        check("nand", 64'(bus.alu_out), 64'hFF0F_FFF0);
        consume();

        // Backpressure: result held, new requests ignored
        issue(OP_ADD, 32'd2, 32'd3, lat, rdy_seen);
        check("bp_first", {bus.out_valid, bus.alu_out}, {1'b1, 32'd5});
        @(negedge clk);
        bus.alu_sel  = OP_SUB;
        bus.a        = 32'd9;
        bus.b        = 32'd9;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_hold", {bus.out_valid, bus.in_ready, bus.zero, bus.alu_out},
                  {1'b1, 1'b0, 1'b0, 32'd5});
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        consume();
        check("bp_release", {bus.out_valid, bus.in_ready, bus.alu_out}, {1'b0, 1'b1, 32'd5});

        // Reset in the middle of a DIV
        @(negedge clk);
        bus.alu_sel  = OP_DIV;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async", {bus.out_valid, bus.in_ready, bus.zero, bus.div_by_zero, bus.carry_out, bus.alu_out},
              {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("rst_no_result", {bus.out_valid, bus.in_ready}, {1'b0, 1'b1});

        // MUL after reset
        issue(OP_MUL, 32'h0000_FFFF, 32'h0000_FFFF, lat, rdy_seen);
        check("mul_lat", 64'(lat), 64'(MUL_LAT));
        check("mul_res", {bus.zero, bus.carry_out, bus.alu_out}, {1'b0, 1'b0, 32'hFFFE_0001});
        consume();
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, lat, rdy_seen);
        check("mul_wrap", {bus.zero, bus.alu_out}, {1'b1, 32'h0});
        consume();
        issue(OP_MUL, 32'd12345, 32'd0, lat, rdy_seen);
        check("mul_b0", {bus.div_by_zero, bus.zero, bus.alu_out}, {1'b0, 1'b1, 32'h0});
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
